// File: rtl/neureka_acc_ctrl_if.sv
// Handshake and adder-strobe bundle between the accumulator sequencer and its
// neighbours. master = sequencer side, slave = producer/consumer/datapath side.
interface neureka_acc_ctrl_if #(
  parameter int unsigned NADD = 4
);
  // valid/ready: a transfer happens in any cycle where both are high at the
  // rising clock edge; valid, once raised by the sender, is never withdrawn
  // by this block before the matching ready.
  logic            psum_valid;
  logic            psum_ready;
  logic [NADD-1:0] bypass;
  logic [NADD-1:0] enable;
  logic            acc_we;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  psum_valid, out_ready,
    output psum_ready, bypass, enable, acc_we, out_valid
  );

  modport slave (
    output psum_valid, out_ready,
    input  psum_ready, bypass, enable, acc_we, out_valid
  );
endinterface

// File: rtl/neureka_accumulator_ctrl.sv
// Accumulator sequencer: K partial-sum beats per tile, T tiles per job, then drain.
// Optional stall counter enabled by defining NEUREKA_ACC_CTRL_PERF_EN.
package neureka_package;
  parameter int unsigned NEUREKA_TP_OUT = 32;
endpackage

module neureka_accumulator_ctrl #(
  parameter int unsigned NADD   = neureka_package::NEUREKA_TP_OUT,
  parameter int unsigned ITER_W = 16,
  parameter int unsigned TILE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_mode_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] nb_kin_iter_i,
  input  logic [TILE_W-1:0] nb_tiles_i,
  input  logic [NADD-1:0]   lane_mask_i,
  neureka_acc_ctrl_if.master acc_if,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic [TILE_W-1:0] tile_cnt_o,
  output logic [31:0]       stall_cnt_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d, kin_q, kin_d;
  logic [TILE_W-1:0] tile_q, tile_d, tiles_q, tiles_d;
  logic [NADD-1:0]   mask_q, mask_d;

  logic            psum_ready, out_valid, acc_we, busy, done, start_acc;
  logic [NADD-1:0] bypass, enable;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    tile_d     = tile_q;
    kin_d      = kin_q;
    tiles_d    = tiles_q;
    mask_d     = mask_q;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    acc_we     = 1'b0;
    bypass     = '0;
    enable     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          kin_d     = nb_kin_iter_i;
          tiles_d   = nb_tiles_i;
          mask_d    = lane_mask_i;
          iter_d    = '0;
          tile_d    = '0;
          start_acc = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = 1'b1;
        busy       = 1'b1;
        if (acc_if.psum_valid) begin
          acc_we = 1'b1;
          // First beat of a tile overwrites the accumulator; later beats add.
          if (iter_q == '0) bypass = mask_q;
          else              enable = mask_q;
          if (iter_q == kin_q) begin
            iter_d  = '0;
            state_d = DRAIN;
          end else begin
            iter_d = iter_q + ITER_W'(1);
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (acc_if.out_ready) begin
          if (tile_q == tiles_q) begin
            state_d = DONE;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over start and any handshake in the same cycle.
    if (clear_i) begin
      state_d = IDLE;
      iter_d  = '0;
      tile_d  = '0;
      kin_d   = '0;
      tiles_d = '0;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      iter_q  <= '0;
      tile_q  <= '0;
      kin_q   <= '0;
      tiles_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      tile_q  <= tile_d;
      kin_q   <= kin_d;
      tiles_q <= tiles_d;
      mask_q  <= mask_d;
    end
  end

`ifdef NEUREKA_ACC_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (((state_q == ACCUM) && !acc_if.psum_valid) ||
                 ((state_q == DRAIN) && !acc_if.out_ready)) begin
      if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    end
    if (clear_i) stall_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign stall_cnt_o      = '0;
`endif

  assign acc_if.psum_ready = psum_ready;
  assign acc_if.out_valid  = out_valid;
  assign acc_if.acc_we     = acc_we;
  assign acc_if.bypass     = bypass;
  assign acc_if.enable     = enable;
  assign busy_o            = busy;
  assign done_o            = done;
  assign iter_cnt_o        = iter_q;
  assign tile_cnt_o        = tile_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_neureka_accumulator_ctrl.sv
// Self-checking bench for neureka_accumulator_ctrl: job-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_neureka_accumulator_ctrl;
  localparam int NADD   = 4;
  localparam int ITER_W = 16;
  localparam int TILE_W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              test_mode;
  logic              clear;
  logic              start;
  logic [ITER_W-1:0] kin;
  logic [TILE_W-1:0] tiles;
  logic [NADD-1:0]   mask;
  logic              busy, done;
  logic [ITER_W-1:0] iter_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic [31:0]       stall_cnt;
  logic [1:0]        state_dbg;

  neureka_acc_ctrl_if #(.NADD(NADD)) acc_if ();

  neureka_accumulator_ctrl #(.NADD(NADD), .ITER_W(ITER_W), .TILE_W(TILE_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_mode_i   (test_mode),
    .clear_i       (clear),
    .start_i       (start),
    .nb_kin_iter_i (kin),
    .nb_tiles_i    (tiles),
    .lane_mask_i   (mask),
    .acc_if        (acc_if),
    .busy_o        (busy),
    .done_o        (done),
    .iter_cnt_o    (iter_cnt),
    .tile_cnt_o    (tile_cnt),
    .stall_cnt_o   (stall_cnt),
    .state_o       (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job-level counts) ----------------
  int              m_k, m_t, m_beats, m_tiles;
  logic [NADD-1:0] m_mask;
  bit              m_run, m_drain, m_done;
  longint          m_stall;

  task automatic model_reset();
    m_k = 0; m_t = 0; m_beats = 0; m_tiles = 0; m_mask = '0;
    m_run = 0; m_drain = 0; m_done = 0; m_stall = 0;
  endtask

  // Predict what this edge does from the inputs currently applied.
  task automatic model_advance();
    if (!rst_n || clear) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start) begin
        m_k = int'(kin) + 1; m_t = int'(tiles) + 1; m_mask = mask;
        m_run = 1; m_beats = 0; m_tiles = 0; m_stall = 0;
      end
    end else if (!m_drain) begin
      if (acc_if.psum_valid) begin
        m_beats++;
        if (m_beats == m_k) begin m_beats = 0; m_drain = 1; end
      end else if (m_stall < 64'hFFFF_FFFF) m_stall++;
    end else begin
      if (acc_if.out_ready) begin
        m_drain = 0;
        m_tiles++;
        if (m_tiles == m_t) begin m_run = 0; m_done = 1; end
      end else if (m_stall < 64'hFFFF_FFFF) m_stall++;
    end
  endtask

  task automatic model_compare();
    logic            e_rdy, e_we;
    logic [NADD-1:0] e_byp, e_en;
    longint          e_stall;
    e_rdy = m_run && !m_drain;
    e_we  = e_rdy && acc_if.psum_valid;
    e_byp = (e_we && m_beats == 0) ? m_mask : '0;
    e_en  = (e_we && m_beats != 0) ? m_mask : '0;
`ifdef NEUREKA_ACC_CTRL_PERF_EN
    e_stall = m_stall;
`else
    e_stall = 0;
`endif
    check("busy",       busy,              m_run || m_done);
    check("done",       done,              m_done);
    check("psum_ready", acc_if.psum_ready, e_rdy);
    check("out_valid",  acc_if.out_valid,  m_run && m_drain);
    check("acc_we",     acc_if.acc_we,     e_we);
    check("bypass",     acc_if.bypass,     e_byp);
    check("enable",     acc_if.enable,     e_en);
    check("stall_cnt",  stall_cnt,         e_stall);
    if (m_run) begin
      check("iter_cnt", iter_cnt, m_beats);
      check("tile_cnt", tile_cnt, m_tiles);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    if (chk_on) model_compare();
    model_advance();
  end

  // ---------------- driver + per-job statistics ----------------
  int              st_byp, st_en, st_hs, st_first_ov, st_done_cyc;
  logic [NADD-1:0] st_or;
  logic [ITER_W-1:0] st_iter[$];
  logic [TILE_W-1:0] st_tiles[$];
  bit              vpat[$];

  // vmode: 0 always valid, 1 random, 2 pattern queue then valid
  // rmode: 0 always ready, 1 random, 2 ready low for the first 3 cycles of each drain
  task automatic run_job(input int kin_v, input int tiles_v, input logic [NADD-1:0] mask_v,
                         input int vmode, input int rmode, input bit noise, input int budget);
    int cyc, wait_cnt;
    bit fin;
    st_byp = 0; st_en = 0; st_hs = 0; st_first_ov = -1; st_done_cyc = -1; st_or = '0;
    st_iter.delete(); st_tiles.delete();
    cyc = 0; wait_cnt = 0; fin = 0;
    @(posedge clk); #1;
    kin = ITER_W'(kin_v); tiles = TILE_W'(tiles_v); mask = mask_v; start = 1'b1;
    acc_if.psum_valid = (vmode != 2);
    acc_if.out_ready  = (rmode == 0);
    while (!fin && cyc < budget) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = noise && ($urandom_range(0, 3) == 0);
        kin   = ITER_W'($urandom); tiles = TILE_W'($urandom); mask = NADD'($urandom);
        case (vmode)
          0: acc_if.psum_valid = 1'b1;
          1: acc_if.psum_valid = ($urandom_range(0, 9) < 7);
          default: acc_if.psum_valid = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
        endcase
        case (rmode)
          0: acc_if.out_ready = 1'b1;
          1: acc_if.out_ready = ($urandom_range(0, 1) == 1);
          default: acc_if.out_ready = (wait_cnt >= 3);
        endcase
      end
      @(negedge clk);
      if (acc_if.acc_we) begin
        if (acc_if.bypass != '0) st_byp++;
        if (acc_if.enable != '0) st_en++;
        st_or |= acc_if.bypass | acc_if.enable;
      end
      if (acc_if.psum_ready) st_iter.push_back(iter_cnt);
      if (acc_if.out_valid && st_first_ov < 0) st_first_ov = cyc;
      if (acc_if.out_valid && acc_if.out_ready) begin
        st_hs++; st_tiles.push_back(tile_cnt); wait_cnt = 0;
      end else if (acc_if.out_valid) wait_cnt++;
      if (done) begin st_done_cyc = cyc; fin = 1; end
      cyc++;
    end
    if (!fin) check("job_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start a long job and stop once iter_cnt_o reads 5 just after an edge.
  task automatic start_until_iter5();
    int n;
    @(posedge clk); #1;
    kin = 16'd9; tiles = '0; mask = 4'hF; start = 1'b1;
    acc_if.psum_valid = 1'b1; acc_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (iter_cnt != 16'd5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("iter5_timeout", 0, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy,              1'b0);
    check({tag, "_ready"}, acc_if.psum_ready, 1'b0);
    check({tag, "_we"},    acc_if.acc_we,     1'b0);
    check({tag, "_byp"},   acc_if.bypass,     4'h0);
    check({tag, "_iter"},  iter_cnt,          16'd0);
  endtask

  // ---------------- scenarios ----------------
  localparam bit [3:0] PAT4 = 4'b0000;
  int k, t;
  logic [NADD-1:0] rm;
  bit nz;
  longint exp_stall12;

  initial begin
    rst_n = 1'b0; test_mode = 1'b0; clear = 1'b0; start = 1'b0;
    kin = '0; tiles = '0; mask = '0;
    acc_if.psum_valid = 1'b0; acc_if.out_ready = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  busy,             1'b0);
    check("rst_ovld",  acc_if.out_valid, 1'b0);
    check("rst_done",  done,             1'b0);
    check("rst_tile",  tile_cnt,         16'd0);
    check("rst_stall", stall_cnt,        32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // K=3, T=1, full mask, continuous valid
    run_job(2, 0, 4'hF, 0, 0, 0, 60);
    check("t1_byp_beats", st_byp,      1);
    check("t1_en_beats",  st_en,       2);
    check("t1_lanes",     st_or,       4'hF);
    check("t1_ovld_cyc",  st_first_ov, 4);
    check("t1_done_cyc",  st_done_cyc, 5);
    check("t1_hs",        st_hs,       1);

    // K=1, T=4, downstream stalls 3 cycles per tile
    run_job(0, 3, 4'hF, 0, 2, 0, 100);
`ifdef NEUREKA_ACC_CTRL_PERF_EN
    exp_stall12 = 12;
`else
    exp_stall12 = 0;
`endif
    check("t2_hs",    st_hs,  4);
    check("t2_byp",   st_byp, 4);
    check("t2_en",    st_en,  0);
    check("t2_stall", stall_cnt, exp_stall12);
    for (int i = 0; i < 4; i++)
      check("t2_tile_seq", (st_tiles.size() > i) ? st_tiles[i] : 16'hFFFF, i);

    // Sparse lane mask, K=2
    run_job(1, 0, 4'b0101, 0, 0, 0, 60);
    check("t3_lanes", st_or,  4'b0101);
    check("t3_byp",   st_byp, 1);
    check("t3_en",    st_en,  1);

    // Valid drops mid-tile, K=3
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_job(2, 0, 4'hF, 2, 0, 0, 60);
    begin
      int exp_iter[5] = '{0, 1, 1, 1, 2};
      for (int i = 0; i < 5; i++)
        check("t4_iter_seq", (st_iter.size() > i) ? st_iter[i] : 16'hFFFF, exp_iter[i]);
    end
    check("t4_ovld_cyc", st_first_ov, 6);
    check("t4_en",       st_en,       2);

    // Async reset mid-ACCUM, then restart
    start_until_iter5();
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("t5r");
    @(posedge clk); #1 rst_n = 1'b1;
    run_job(1, 0, 4'hF, 0, 0, 0, 60);
    check("t5r_first_iter", (st_iter.size() > 0) ? st_iter[0] : 16'hFFFF, 0);
    check("t5r_byp", st_byp, 1);

    // Synchronous clear mid-ACCUM, then restart
    start_until_iter5();
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check_idle("t5c");
    run_job(1, 0, 4'hF, 0, 0, 0, 60);
    check("t5c_first_iter", (st_iter.size() > 0) ? st_iter[0] : 16'hFFFF, 0);
    check("t5c_byp", st_byp, 1);

    // Stray start pulses and scrambled config during the job
    run_job(3, 2, 4'hF, 1, 1, 1, 400);
    check("t6_hs",  st_hs,  3);
    check("t6_byp", st_byp, 3);
    check("t6_en",  st_en,  9);

    // Randomized jobs
    repeat (10) begin
      k  = $urandom_range(0, 5);
      t  = $urandom_range(0, 3);
      rm = NADD'($urandom_range(1, 15));
      nz = ($urandom_range(0, 1) == 1);
      run_job(k, t, rm, 1, 1, nz, 600);
      check("rnd_hs",  st_hs,  t + 1);
      check("rnd_byp", st_byp, t + 1);
      check("rnd_en",  st_en,  k * (t + 1));
      check("rnd_lanes", st_or, rm);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/neureka_accumulator_ctrl.md
Name: neureka_accumulator_ctrl

Overview:
Sequencer for the NADD-lane accumulator adder datapath.
- Runs a job of T output tiles. Each tile accumulates K partial-sum beats, then drains the result downstream.
- Per accepted beat it drives the adder's per-lane bypass/enable vectors and the accumulator write strobe. The first beat of a tile overwrites, later beats add.
- Sits between the partial-sum producer (valid/ready stream) and the accumulator-bank / normquant consumer (valid/ready stream).

Parameters:
- NADD, neureka_package::NEUREKA_TP_OUT, number of accumulator lanes.
- ITER_W, 16, width of the K-iteration counter.
- TILE_W, 16, width of the tile counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_mode_i  in  1  test mode; no functional effect
- clear_i  in  1  synchronous clear
- start_i  in  1  job start pulse; sampled only in IDLE
- nb_kin_iter_i  in  ITER_W  beats per tile minus one (0 = 1 beat)
- nb_tiles_i  in  TILE_W  tiles per job minus one
- lane_mask_i  in  NADD  active lanes
- psum_valid_i  in  1  partial-sum beat valid
- psum_ready_o  out  1  partial-sum beat accept
- bypass_o  out  NADD  per-lane overwrite select to adder
- enable_o  out  NADD  per-lane add select to adder
- acc_we_o  out  1  accumulator register write strobe
- out_valid_o  out  1  tile result valid
- out_ready_i  in  1  downstream accepts tile result
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- iter_cnt_o  out  ITER_W  current beat index within tile
- tile_cnt_o  out  TILE_W  current tile index
- stall_cnt_o  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset (rst_ni low, async): state IDLE; all outputs 0; counters 0; latched config 0.
- clear_i: same effect as reset, applied at the clock edge. Has priority over every other event, including start_i and handshakes.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - psum_ready_o=0, busy_o=0.
  - On start_i, latch nb_kin_iter_i, nb_tiles_i and lane_mask_i; zero both counters; go to ACCUM next cycle.
- ACCUM:
  - psum_ready_o=1, busy_o=1.
  - Beat transfer = psum_valid_i & psum_ready_o. All strobes below are combinational in the transfer cycle.
  - acc_we_o=1.
  - If iter_cnt==0: bypass_o=mask, enable_o=0. Otherwise: bypass_o=0, enable_o=mask.
  - Masked-off lanes get bypass=enable=0, so they hold their value.
  - With no transfer: bypass_o=enable_o=0, acc_we_o=0.
  - On transfer with iter_cnt==K-1: iter_cnt wraps to 0; go to DRAIN. Otherwise iter_cnt increments.
- DRAIN:
  - psum_ready_o=0, out_valid_o=1, held until out_ready_i.
  - Last beat accepted at edge t gives out_valid_o high from cycle t+1.
  - On out handshake: if tile_cnt==T-1, go to DONE. Otherwise tile_cnt increments and state returns to ACCUM.
  - No beat is accepted in the handshake cycle.
- DONE: done_o=1 for exactly one cycle; busy_o=1; then IDLE.
- start_i outside IDLE is ignored. Config inputs are ignored after latching.
- Single-beat tiles (K=1): every beat is a bypass beat; enable_o is never asserted.
- psum_valid_i dropping mid-tile: no strobes, counters hold; no timeout.
- out_valid_o must not deassert before out_ready_i.
- Max job: K=2^ITER_W, T=2^TILE_W; counters never overflow because they wrap at the latched limit.

Optional Feature:
- Macro: NEUREKA_ACC_CTRL_PERF_EN.
- Defined: stall_cnt_o counts cycles with (ACCUM & ~psum_valid_i) | (DRAIN & ~out_ready_i).
  - Zeroed on start acceptance, reset and clear_i.
  - Saturates at 2^32-1.
  - Holds its value after done.
- Undefined: stall_cnt_o tied to 0; no counter flops.

Test Plan:
1. K=3 (nb_kin_iter_i=2), T=1, mask all-ones, psum_valid_i constant 1 -> beat 0: bypass_o=all-ones, enable_o=0; beats 1,2: enable_o=all-ones; out_valid_o at cycle 4 after start; done_o pulse one cycle after out handshake.
2. K=1, T=4, out_ready_i low for 3 cycles per tile -> 4 bypass-only beats, 4 out handshakes, tile_cnt_o 0..3, enable_o never high; with PERF_EN, stall_cnt_o=12.
3. mask=0b0101 (NADD=4), K=2 -> bypass_o=0b0101, then enable_o=0b0101; lanes 1 and 3 never strobed.
4. psum_valid_i toggling 1,0,0,1,1 with K=3 -> strobes only on valid cycles; iter_cnt_o sequence 0,1,1,1,2; transition to DRAIN after the fifth cycle.
5. rst_ni low, then clear_i high, each mid-ACCUM with iter_cnt=5 -> next cycle IDLE, all outputs 0; a new start_i restarts with iter_cnt 0 and a bypass beat.
6. start_i pulsed during ACCUM and during DRAIN -> ignored; latched K/T unchanged; job completes with the original counts.
